// File: rtl/controller.sv
// Switch-selectable 16-LED chaser: a one-hot pattern rotates once per mode_clock period,
// where mode_clock is a 50%-duty divide of CLOCK chosen by SW (0 = stopped).
module controller #(
   parameter int unsigned DIV1 = 1000,
   parameter int unsigned DIV2 = 500,
   parameter int unsigned DIV3 = 200
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic [1:0]  SW,
   output logic [15:0] LD,
   output logic        mode_clock
);

   localparam int unsigned DIV_MAX = (DIV1 > DIV2) ? ((DIV1 > DIV3) ? DIV1 : DIV3)
                                                   : ((DIV2 > DIV3) ? DIV2 : DIV3);
   localparam int unsigned CW = $clog2(DIV_MAX);

   localparam logic [1:0] MODE_STOP = 2'd0;
   localparam logic [1:0] MODE_DIV1 = 2'd1;
   localparam logic [1:0] MODE_DIV2 = 2'd2;
   localparam logic [1:0] MODE_DIV3 = 2'd3;

   localparam logic [CW-1:0] END1  = CW'(DIV1 - 1);
   localparam logic [CW-1:0] END2  = CW'(DIV2 - 1);
   localparam logic [CW-1:0] END3  = CW'(DIV3 - 1);
   localparam logic [CW-1:0] HALF1 = CW'(DIV1 / 2 - 1);
   localparam logic [CW-1:0] HALF2 = CW'(DIV2 / 2 - 1);
   localparam logic [CW-1:0] HALF3 = CW'(DIV3 / 2 - 1);

   logic [1:0]    r_sw_q;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_pattern;
   logic          r_mode_clk;

   logic [CW-1:0] w_end;
   logic [CW-1:0] w_half;

   always_comb begin
      w_end  = '0;
      w_half = '0;
      case (r_sw_q)
         MODE_DIV1: begin w_end = END1; w_half = HALF1; end
         MODE_DIV2: begin w_end = END2; w_half = HALF2; end
         MODE_DIV3: begin w_end = END3; w_half = HALF3; end
         default:   begin w_end = '0;   w_half = '0;    end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sw_q     <= MODE_STOP;
         r_cnt      <= '0;
         r_mode_clk <= 1'b0;
         r_pattern  <= 16'h0001;
      end else begin
         r_sw_q <= SW;
         // A switch change restarts the divider; the LED position survives unless stopping.
         if (SW != r_sw_q) begin
            r_cnt      <= '0;
            r_mode_clk <= 1'b0;
            if (SW == MODE_STOP)
               r_pattern <= 16'h0001;
         end else if (r_sw_q == MODE_STOP) begin
            r_cnt      <= '0;
            r_mode_clk <= 1'b0;
            r_pattern  <= 16'h0001;
         end else if (r_cnt == w_end) begin
            r_cnt      <= '0;
            r_mode_clk <= 1'b1;
            r_pattern  <= {r_pattern[14:0], r_pattern[15]};
         end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == w_half)
               r_mode_clk <= 1'b0;
         end
      end
   end

   assign LD         = (r_sw_q == MODE_STOP) ? 16'h0000 : r_pattern;
   assign mode_clock = r_mode_clk;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: reset/stop, each run rate, rate switching and mid-run reset.
module tb_controller;

   logic        CLOCK;
   logic        RESET_N;
   logic [1:0]  SW;
   logic [15:0] LD;
   logic        mode_clock;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   controller #(.DIV1(1000), .DIV2(500), .DIV3(200)) dut (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .SW         (SW),
      .LD         (LD),
      .mode_clock (mode_clock)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] v, input int unsigned k);
      logic [15:0] r;
      r = v;
      for (int unsigned i = 0; i < (k % 16); i++)
         r = {r[14:0], r[15]};
      return r;
   endfunction

   task automatic test_reset_stop();
      int unsigned bad;
      RESET_N = 1'b0;
      SW      = 2'd0;
      #3;
      n_checks++;
      if (LD !== 16'h0000) $display("FAIL reset_ld: got %h expected 0000", LD);
      else n_pass++;
      n_checks++;
      if (mode_clock !== 1'b0) $display("FAIL reset_mc: got %b expected 0", mode_clock);
      else n_pass++;
      tick();
      RESET_N = 1'b1;
      bad = 0;
      for (int unsigned k = 0; k < 1000; k++) begin
         tick();
         if (LD !== 16'h0000 || mode_clock !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL stop_mode: %0d bad cycles, expected 0 (LD=0000, mc=0)", bad);
      else n_pass++;
   endtask

   // SW is applied before the next edge (the change edge, cycle 0); then steps*n cycles follow.
   task automatic test_run(input string name, input logic [1:0] sw, input int unsigned n,
                           input int unsigned steps, input logic [15:0] start, input bit want_wrap);
      int unsigned mc_bad, ld_bad, nsteps, first_bad;
      logic [15:0] prev, exp_ld;
      logic        exp_mc;
      bit          wrap;
      mc_bad = 0; ld_bad = 0; nsteps = 0; first_bad = 0; wrap = 0;
      SW = sw;
      prev = start;
      for (int unsigned k = 0; k <= steps * n; k++) begin
         tick();
         exp_ld = rotl(start, k / n);
         exp_mc = (k >= n) && (((k - n) % n) < (n / 2));
         if (mode_clock !== exp_mc) begin
            if (mc_bad == 0 && ld_bad == 0) first_bad = k;
            mc_bad++;
         end
         if (LD !== exp_ld) begin
            if (mc_bad == 0 && ld_bad == 0) first_bad = k;
            ld_bad++;
         end
         if (k > 0 && LD !== prev) nsteps++;
         if (prev == 16'h8000 && LD == 16'h0001) wrap = 1;
         prev = LD;
      end
      n_checks++;
      if (mc_bad != 0) $display("FAIL %s_mc_wave: %0d bad cycles (first near %0d), expected 0", name, mc_bad, first_bad);
      else n_pass++;
      n_checks++;
      if (ld_bad != 0) $display("FAIL %s_ld_seq: %0d bad cycles (first near %0d), expected 0", name, ld_bad, first_bad);
      else n_pass++;
      n_checks++;
      if (nsteps != steps) $display("FAIL %s_steps: got %0d expected %0d", name, nsteps, steps);
      else n_pass++;
      n_checks++;
      if (LD !== rotl(start, steps)) $display("FAIL %s_final_ld: got %h expected %h", name, LD, rotl(start, steps));
      else n_pass++;
      if (want_wrap) begin
         n_checks++;
         if (!wrap) $display("FAIL %s_wrap: got no 8000->0001 step, expected one", name);
         else n_pass++;
      end
   endtask

   task automatic test_switch_3_to_1();
      logic [15:0] held;
      for (int unsigned k = 0; k < 50; k++) tick();
      held = LD;
      n_checks++;
      if (mode_clock !== 1'b1) $display("FAIL sw3to1_pre_mc: got %b expected 1", mode_clock);
      else n_pass++;
      test_run("sw3to1", 2'd1, 1000, 2, held, 1'b0);
   endtask

   task automatic test_reset_midrun();
      int unsigned waited;
      waited = 0;
      while (LD !== 16'h0040 && waited < 20000) begin
         tick();
         waited++;
      end
      n_checks++;
      if (LD !== 16'h0040) $display("FAIL rst_reach_0040: got %h expected 0040", LD);
      else n_pass++;
      for (int unsigned k = 0; k < 100; k++) tick();
      n_checks++;
      if (mode_clock !== 1'b1) $display("FAIL rst_pre_mc: got %b expected 1", mode_clock);
      else n_pass++;
      #2 RESET_N = 1'b0;
      #1;
      n_checks++;
      if (LD !== 16'h0000) $display("FAIL rst_async_ld: got %h expected 0000", LD);
      else n_pass++;
      n_checks++;
      if (mode_clock !== 1'b0) $display("FAIL rst_async_mc: got %b expected 0", mode_clock);
      else n_pass++;
      tick();
      tick();
      #2 RESET_N = 1'b1;
      test_run("rst_release", 2'd1, 1000, 2, 16'h0001, 1'b0);
   endtask

   initial begin
      test_reset_stop();
      test_run("sw1", 2'd1, 1000, 32, 16'h0001, 1'b1);
      test_run("sw2", 2'd2, 500, 32, 16'h0001, 1'b1);
      test_run("sw3", 2'd3, 200, 32, 16'h0001, 1'b1);
      test_switch_3_to_1();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
